// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped GPIO bank: register offsets,
// the per-channel address stride and the default window base.
package mmio_pkg;

    localparam logic [1:0]  OFF_OUT      = 2'd0;
    localparam logic [1:0]  OFF_IN       = 2'd1;
    localparam logic [1:0]  OFF_EDGE     = 2'd2;
    localparam logic [1:0]  OFF_MASK     = 2'd3;

    localparam int          CH_STRIDE    = 16;
    localparam logic [31:0] DEFAULT_BASE = 32'h1001_0000;

    // Byte size of the address window occupied by numCh channels.
    function automatic logic [31:0] windowBytes(input int numCh);
        return 32'(CH_STRIDE * numCh);
    endfunction

endpackage

// File: rtl/mmio_port_channel.sv
// One GPIO channel: latched output, two-flop input synchroniser and, when
// MMIO_EDGE_IRQ_EN is defined, sticky rising-edge flags with an interrupt mask.
module mmio_port_channel
    import mmio_pkg::*;
#(
    parameter int PORT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wrOut,
    input  logic                  wrEdge,
    input  logic                  wrMask,
    input  logic [PORT_WIDTH-1:0] wrData,
    input  logic [PORT_WIDTH-1:0] pinIn,
    output logic [PORT_WIDTH-1:0] outVal,
    output logic [PORT_WIDTH-1:0] inVal,
    output logic [PORT_WIDTH-1:0] edgeVal,
    output logic [PORT_WIDTH-1:0] maskVal,
    output logic                  irq
);

    logic [PORT_WIDTH-1:0] outReg;
    logic [PORT_WIDTH-1:0] syncS1;
    logic [PORT_WIDTH-1:0] syncS2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outReg <= '0;
            syncS1 <= '0;
            syncS2 <= '0;
        end else begin
            syncS1 <= pinIn;
            syncS2 <= syncS1;
            if (wrOut) begin
                outReg <= wrData;
            end
        end
    end

    assign outVal = outReg;
    assign inVal  = syncS2;

`ifdef MMIO_EDGE_IRQ_EN
    logic [PORT_WIDTH-1:0] prevS2;
    logic [PORT_WIDTH-1:0] edgeReg;
    logic [PORT_WIDTH-1:0] maskReg;
    logic [PORT_WIDTH-1:0] riseBits;
    logic [PORT_WIDTH-1:0] clearBits;

    assign riseBits  = syncS2 & ~prevS2;
    assign clearBits = wrEdge ? wrData : '0;

    // A rise arriving in the same cycle as a write-1-to-clear keeps its flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prevS2  <= '0;
            edgeReg <= '0;
            maskReg <= '0;
        end else begin
            prevS2  <= syncS2;
            edgeReg <= (edgeReg & ~clearBits) | riseBits;
            if (wrMask) begin
                maskReg <= wrData;
            end
        end
    end

    assign edgeVal = edgeReg;
    assign maskVal = maskReg;
    assign irq     = |(edgeReg & maskReg);
`else
    logic unusedCfg;

    assign edgeVal   = '0;
    assign maskVal   = '0;
    assign irq       = 1'b0;
    assign unusedCfg = &{1'b0, wrEdge, wrMask};
`endif

endmodule

// File: rtl/mmio_port_bank.sv
// Memory-mapped GPIO bank beside DataMemory: address decode, read mux and
// interrupt OR over NUM_CH channels. Edge/IRQ logic gated by MMIO_EDGE_IRQ_EN.
module mmio_port_bank
    import mmio_pkg::*;
#(
    parameter int          NUM_CH     = 2,
    parameter int          PORT_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  Address,
    input  logic [31:0]                  WriteData,
    input  logic                         MemWrite,
    input  logic                         MemRead,
    output logic [31:0]                  ReadData,
    output logic                         Hit,
    input  logic [NUM_CH*PORT_WIDTH-1:0] PortIn,
    output logic [NUM_CH*PORT_WIDTH-1:0] PortOut,
    output logic                         Irq
);

    localparam logic [31:0] WINDOW = windowBytes(NUM_CH);

    logic [31:0]           offset;
    logic [3:0]            chSel;
    logic [1:0]            regSel;
    logic                  writeHit;
    logic [PORT_WIDTH-1:0] outVal  [NUM_CH];
    logic [PORT_WIDTH-1:0] inVal   [NUM_CH];
    logic [PORT_WIDTH-1:0] edgeVal [NUM_CH];
    logic [PORT_WIDTH-1:0] maskVal [NUM_CH];
    logic [NUM_CH-1:0]     chIrq;
    logic [PORT_WIDTH-1:0] regVal;
    logic                  unusedBits;

    // Subtracting the base keeps the decode correct for any aligned window size.
    assign offset   = Address - BASE_ADDR;
    assign Hit      = offset < WINDOW;
    assign chSel    = offset[7:4];
    assign regSel   = offset[3:2];
    assign writeHit = MemWrite & Hit;

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : gCh
            logic chWr;

            assign chWr = writeHit && (chSel == 4'(k));

            mmio_port_channel #(
                .PORT_WIDTH (PORT_WIDTH)
            ) uChannel (
                .clk     (clk),
                .reset   (reset),
                .wrOut   (chWr && (regSel == OFF_OUT)),
                .wrEdge  (chWr && (regSel == OFF_EDGE)),
                .wrMask  (chWr && (regSel == OFF_MASK)),
                .wrData  (WriteData[PORT_WIDTH-1:0]),
                .pinIn   (PortIn[k*PORT_WIDTH +: PORT_WIDTH]),
                .outVal  (outVal[k]),
                .inVal   (inVal[k]),
                .edgeVal (edgeVal[k]),
                .maskVal (maskVal[k]),
                .irq     (chIrq[k])
            );

            assign PortOut[k*PORT_WIDTH +: PORT_WIDTH] = outVal[k];
        end
    endgenerate

    always_comb begin
        regVal = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (chSel == 4'(k)) begin
                case (regSel)
                    OFF_OUT:  regVal = outVal[k];
                    OFF_IN:   regVal = inVal[k];
                    OFF_EDGE: regVal = edgeVal[k];
                    default:  regVal = maskVal[k];
                endcase
            end
        end
    end

    assign ReadData = Hit ? 32'(regVal) : 32'd0;
    assign Irq      = |chIrq;

    // MemRead only exists for bus compatibility; reads are always live on Hit.
    assign unusedBits = &{1'b0, MemRead, WriteData, offset};

endmodule

// File: tb/tb_mmio_port_bank.sv
// Self-checking bench for mmio_port_bank (NUM_CH=2, PORT_WIDTH=8) against a
// register-level model; expectations follow the build's MMIO_EDGE_IRQ_EN setting.
module tb_mmio_port_bank;

    localparam logic [31:0] BASE = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        Hit;
    logic [15:0] PortIn;
    logic [15:0] PortOut;
    logic        Irq;

    int checks = 0;
    int errors = 0;

    // Model state: register contents plus the PortIn values seen at the
    // last three rising edges (samp[0] newest).
    logic [7:0]  outM  [2];
    logic [7:0]  maskM [2];
    logic [7:0]  edgeM [2];
    logic [15:0] samp  [3];

    mmio_port_bank #(
        .NUM_CH     (2),
        .PORT_WIDTH (8),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .ReadData  (ReadData),
        .Hit       (Hit),
        .PortIn    (PortIn),
        .PortOut   (PortOut),
        .Irq       (Irq)
    );

    always #5 clk = ~clk;

    function automatic logic edgeBuild();
`ifdef MMIO_EDGE_IRQ_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic expHit(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd32);
    endfunction

    function automatic logic [31:0] expRead(input logic [31:0] a);
        logic [31:0] off;
        logic [15:0] visible;
        int ch;
        if (!expHit(a)) return 32'd0;
        off     = a - BASE;
        ch      = (off >= 32'd16) ? 1 : 0;
        // The IN register shows what was on the pins two edges back.
        visible = samp[1];
        case ((off % 32'd16) / 32'd4)
            32'd0:   return {24'd0, outM[ch]};
            32'd1:   return {24'd0, visible[ch*8 +: 8]};
            32'd2:   return edgeBuild() ? {24'd0, edgeM[ch]} : 32'd0;
            default: return edgeBuild() ? {24'd0, maskM[ch]} : 32'd0;
        endcase
    endfunction

    function automatic logic expIrq();
        if (!edgeBuild()) return 1'b0;
        return ((edgeM[0] & maskM[0]) != 8'd0) || ((edgeM[1] & maskM[1]) != 8'd0);
    endfunction

    task automatic modelClear();
        for (int c = 0; c < 2; c++) begin
            outM[c]  = 8'd0;
            maskM[c] = 8'd0;
            edgeM[c] = 8'd0;
        end
        for (int i = 0; i < 3; i++) samp[i] = 16'd0;
    endtask

    // Advance one clock and apply the same edge to the model.
    task automatic step();
        logic [15:0] rose;
        logic [31:0] off;
        int          ch;
        int          reg_i;
        @(posedge clk);
        // Rising edge seen between the samples three and two edges back.
        rose = samp[1] & ~samp[2];
        for (int c = 0; c < 2; c++) edgeM[c] = edgeM[c];
        if (MemWrite && expHit(Address)) begin
            off   = Address - BASE;
            ch    = (off >= 32'd16) ? 1 : 0;
            reg_i = int'((off % 32'd16) / 32'd4);
            if (reg_i == 0) outM[ch] = WriteData[7:0];
            if (reg_i == 2) edgeM[ch] = edgeM[ch] & ~WriteData[7:0];
            if (reg_i == 3) maskM[ch] = WriteData[7:0];
        end
        edgeM[0] = edgeM[0] | rose[7:0];
        edgeM[1] = edgeM[1] | rose[15:8];
        samp[2] = samp[1];
        samp[1] = samp[0];
        samp[0] = PortIn;
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        Address   = a;
        WriteData = d;
        MemWrite  = 1'b1;
        step();
        MemWrite  = 1'b0;
    endtask

    task automatic test_reset();
        store(BASE + 32'h00, 32'h0000_00FF);
        store(BASE + 32'h10, 32'h0000_00FF);
        checks++;
        if (PortOut !== 16'hFFFF) begin
            errors++;
            $display("FAIL reset_preload: PortOut=%h expected=%h", PortOut, 16'hFFFF);
        end
        #2;
        reset = 1'b0;
        modelClear();
        #1;
        checks++;
        if (PortOut !== 16'h0000 || Irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: PortOut=%h Irq=%b expected 0000/0", PortOut, Irq);
        end
        @(negedge clk);
        reset = 1'b1;
        step();
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 4; r++) begin
                Address = BASE + 32'(c * 16 + r * 4);
                #1;
                checks++;
                if (ReadData !== 32'd0) begin
                    errors++;
                    $display("FAIL reset_reg ch%0d off%0d: got=%h expected=0", c, r * 4, ReadData);
                end
                step();
            end
        end
    endtask

    task automatic test_out_write();
        logic [7:0] low;
        low = PortOut[7:0];
        store(BASE + 32'h10, 32'h0000_00A5);
        checks++;
        if (PortOut[15:8] !== 8'hA5 || PortOut[7:0] !== low) begin
            errors++;
            $display("FAIL out_write: PortOut=%h expected=%h", PortOut, {8'hA5, low});
        end
        Address = BASE + 32'h10;
        #1;
        checks++;
        if (ReadData !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL out_readback: got=%h expected=%h", ReadData, 32'hA5);
        end
    endtask

    task automatic test_in_sync();
        PortIn[7:0] = 8'h3C;
        Address     = BASE + 32'h04;
        step();
        checks++;
        if (ReadData !== 32'h0 || ReadData !== expRead(Address)) begin
            errors++;
            $display("FAIL in_sync_early: got=%h expected=%h", ReadData, 32'h0);
        end
        step();
        checks++;
        if (ReadData !== 32'h3C || ReadData !== expRead(Address)) begin
            errors++;
            $display("FAIL in_sync_late: got=%h expected=%h", ReadData, 32'h3C);
        end
    endtask

    task automatic test_edge_irq();
        PortIn = 16'h0000;
        for (int i = 0; i < 4; i++) step();
        store(BASE + 32'h08, 32'hFF);
        store(BASE + 32'h18, 32'hFF);
        store(BASE + 32'h0C, 32'h01);
        PortIn[0] = 1'b1;
        Address   = BASE + 32'h08;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (Irq !== expIrq() || ReadData !== expRead(Address)) begin
                errors++;
                $display("FAIL edge_rise cyc%0d: Irq=%b edge=%h expected %b/%h",
                         i, Irq, ReadData, expIrq(), expRead(Address));
            end
        end
        checks++;
        if (Irq !== edgeBuild()) begin
            errors++;
            $display("FAIL edge_irq_asserted: Irq=%b expected=%b", Irq, edgeBuild());
        end
        store(BASE + 32'h08, 32'h01);
        checks++;
        if (Irq !== 1'b0 || ReadData !== 32'd0) begin
            errors++;
            $display("FAIL edge_w1c: Irq=%b edge=%h expected 0/0", Irq, ReadData);
        end
        // Rise, keep the flag, then let a second rise land on the clearing edge.
        PortIn[0] = 1'b0;
        for (int i = 0; i < 3; i++) step();
        PortIn[0] = 1'b1;
        for (int i = 0; i < 3; i++) step();
        PortIn[0] = 1'b0;
        for (int i = 0; i < 3; i++) step();
        PortIn[0] = 1'b1;
        step();
        step();
        store(BASE + 32'h08, 32'h01);
        checks++;
        if (ReadData !== {31'd0, edgeBuild()} || ReadData !== expRead(Address) || Irq !== expIrq()) begin
            errors++;
            $display("FAIL edge_set_wins: edge=%h Irq=%b expected %h/%b",
                     ReadData, Irq, {31'd0, edgeBuild()}, expIrq());
        end
        store(BASE + 32'h0C, 32'h00);
        checks++;
        if (Irq !== 1'b0) begin
            errors++;
            $display("FAIL mask_off: Irq=%b expected=0", Irq);
        end
    endtask

    task automatic test_decode();
        logic [31:0] outside [2];
        outside[0] = 32'h1001_0020;
        outside[1] = 32'h1000_FFFC;
        for (int i = 0; i < 2; i++) begin
            Address   = outside[i];
            WriteData = 32'hFFFF_FFFF;
            MemWrite  = 1'b1;
            #1;
            checks++;
            if (Hit !== 1'b0 || ReadData !== 32'd0) begin
                errors++;
                $display("FAIL decode_outside %h: Hit=%b ReadData=%h expected 0/0", outside[i], Hit, ReadData);
            end
            step();
            MemWrite = 1'b0;
        end
        for (int r = 0; r < 8; r++) begin
            Address = BASE + 32'(r * 4) + ((r >= 4) ? 32'd0 : 32'd0) + ((r >= 4) ? 32'd0 : 32'd0);
            Address = BASE + ((r >= 4) ? 32'h10 : 32'h0) + 32'((r % 4) * 4);
            #1;
            checks++;
            if (ReadData !== expRead(Address)) begin
                errors++;
                $display("FAIL decode_nochange %h: got=%h expected=%h", Address, ReadData, expRead(Address));
            end
            step();
        end
        store(BASE + 32'h1E, 32'h0000_005A);
        Address = BASE + 32'h1C;
        #1;
        checks++;
        if (ReadData !== (edgeBuild() ? 32'h5A : 32'h0) || ReadData !== expRead(Address)) begin
            errors++;
            $display("FAIL decode_mask1_alias: got=%h expected=%h", ReadData, expRead(Address));
        end
        step();
        store(BASE + 32'h1C, 32'h0);
    endtask

    task automatic test_back_to_back();
        for (int v = 1; v <= 4; v++) begin
            store(BASE + 32'h00, 32'(v * 17));
            checks++;
            if (PortOut[7:0] !== 8'(v * 17) || PortOut !== {outM[1], outM[0]}) begin
                errors++;
                $display("FAIL back_to_back %0d: PortOut=%h expected=%h", v, PortOut, {outM[1], outM[0]});
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            PortIn    = 16'($urandom);
            WriteData = $urandom;
            MemWrite  = ($urandom_range(0, 2) == 0);
            MemRead   = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 5))
                0:       Address = BASE - 32'($urandom_range(1, 64));
                1:       Address = BASE + 32'($urandom_range(32, 96));
                default: Address = BASE + 32'($urandom_range(0, 31));
            endcase
            #1;
            checks++;
            if (Hit !== expHit(Address) || ReadData !== expRead(Address)) begin
                errors++;
                $display("FAIL random_read %0d addr=%h: Hit=%b ReadData=%h expected %b/%h",
                         i, Address, Hit, ReadData, expHit(Address), expRead(Address));
            end
            step();
            checks++;
            if (PortOut !== {outM[1], outM[0]} || Irq !== expIrq()) begin
                errors++;
                $display("FAIL random_state %0d: PortOut=%h Irq=%b expected %h/%b",
                         i, PortOut, Irq, {outM[1], outM[0]}, expIrq());
            end
        end
        MemWrite = 1'b0;
        MemRead  = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        Address   = 32'd0;
        WriteData = 32'd0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        PortIn    = 16'd0;
        modelClear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();

        test_reset();
        test_out_write();
        test_in_sync();
        test_edge_irq();
        test_decode();
        test_back_to_back();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
